// File: rtl/am74ls158_arb.sv
// Two-requester round-robin arbiter driving the s/g_ controls of an inverting 2:1 mux.
// Latency: request sampled at edge n is granted on the registered outputs after edge n.
// Backpressure: none; an owner keeps the mux while it requests, subject to hold-limit preemption unless locked.
module am74ls158_arb #(
    parameter int MAXHOLD = 16,
    parameter int CNTW    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic lock,
    output logic gnt_a,
    output logic gnt_b,
    output logic s,
    output logic g_,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX    = CNTW'(MAXHOLD);
    localparam logic [CNTW-1:0] CNT_LIM    = CNTW'((MAXHOLD > 0) ? MAXHOLD - 1 : 0);
    localparam logic            PREEMPT_EN = (MAXHOLD != 0);

    // Side encoding for owner/last: 0 = A, 1 = B.
    state_t          state, state_nxt;
    logic            owner, owner_nxt;
    logic            last, last_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic            s_nxt;
    logic            own_req, oth_req, hold_up;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        s_nxt     = s;
        own_req   = (state == OWN_B) ? req_b : req_a;
        oth_req   = (state == OWN_B) ? req_a : req_b;
        // A saturated counter still satisfies the limit, so releasing lock preempts at once.
        hold_up   = PREEMPT_EN && !lock && (cnt >= CNT_LIM);

        case (state)
            IDLE: begin
                if (req_a && (!req_b || last))
                    state_nxt = OWN_A;
                else if (req_b)
                    state_nxt = OWN_B;
            end
            OWN_A, OWN_B: begin
                cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + CNTW'(1);
                owner_nxt = (state == OWN_A);
                if (!own_req)
                    state_nxt = oth_req ? DEAD : IDLE;
                else if (oth_req && hold_up)
                    state_nxt = DEAD;
            end
            DEAD: begin
                if (owner ? req_b : req_a)
                    state_nxt = owner ? OWN_B : OWN_A;
                else if (owner ? req_a : req_b)
                    state_nxt = owner ? OWN_A : OWN_B;
                else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if ((state_nxt == OWN_A || state_nxt == OWN_B) && state_nxt != state) begin
            cnt_nxt  = '0;
            last_nxt = (state_nxt == OWN_B);
        end

        case (state_nxt)
            OWN_A:   s_nxt = 1'b0;
            OWN_B:   s_nxt = 1'b1;
            DEAD:    s_nxt = owner_nxt;
            default: s_nxt = s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
            s     <= 1'b0;
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            g_    <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
            s     <= s_nxt;
            gnt_a <= (state_nxt == OWN_A);
            gnt_b <= (state_nxt == OWN_B);
            g_    <= !(state_nxt == OWN_A || state_nxt == OWN_B);
            busy  <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_am74ls158_arb.sv
// Bench for am74ls158_arb with an inline behavioural model of the am74ls158 mux (a=0101, b=0011).
module tb_am74ls158_arb;

    localparam int MAXHOLD = 4;
    localparam int SA = 0, SB = 1;
    localparam int M_IDLE = 0, M_OWN = 1, M_DEAD = 2;

    logic clk = 1'b0;
    logic rst, req_a, req_b, lock;
    logic gnt_a, gnt_b, s, g_, busy;
    logic [3:0] mux_a = 4'b0101;
    logic [3:0] mux_b = 4'b0011;
    wire  [3:0] y = g_ ? 4'b1111 : ~(s ? mux_b : mux_a);

    am74ls158_arb #(.MAXHOLD(MAXHOLD), .CNTW(5)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .lock(lock),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .s(s), .g_(g_), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: mode, owning/incoming side, unbounded owned-cycle count, last owner.
    int   m_mode = M_IDLE, m_who = SA, m_held = 0, m_last = SB;
    logic m_s = 1'b0;

    function automatic logic side_req(int side);
        return (side == SA) ? req_a : req_b;
    endfunction

    task automatic model_grant(int side);
        m_mode = M_OWN; m_who = side; m_held = 0; m_last = side; m_s = (side == SB);
    endtask

    task automatic model_edge();
        int other;
        if (rst) begin
            m_mode = M_IDLE; m_held = 0; m_last = SB; m_s = 1'b0;
            return;
        end
        other = 1 - m_who;
        case (m_mode)
            M_IDLE: begin
                if (req_a && req_b) model_grant(1 - m_last);
                else if (req_a)     model_grant(SA);
                else if (req_b)     model_grant(SB);
            end
            M_OWN: begin
                if (!side_req(m_who)) begin
                    if (side_req(other)) begin m_mode = M_DEAD; m_who = other; m_s = (other == SB); end
                    else m_mode = M_IDLE;
                end else if (side_req(other) && !lock && MAXHOLD > 0 && m_held + 1 >= MAXHOLD) begin
                    m_mode = M_DEAD; m_who = other; m_s = (other == SB);
                end else begin
                    m_held++;
                end
            end
            default: begin
                if (side_req(m_who))      model_grant(m_who);
                else if (side_req(other)) model_grant(other);
                else                      m_mode = M_IDLE;
            end
        endcase
    endtask

    function automatic logic [4:0] exp_vec();
        logic ga, gb;
        ga = (m_mode == M_OWN) && (m_who == SA);
        gb = (m_mode == M_OWN) && (m_who == SB);
        return {ga, gb, m_s, ~(ga | gb), logic'(m_mode != M_IDLE)};
    endfunction

    function automatic logic [4:0] dut_vec();
        return {gnt_a, gnt_b, s, g_, busy};
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; lock = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_a = 1'b1; req_b = 1'b1; lock = 1'b0;
        step(); step();
        checks++;
        if ({g_, gnt_a, gnt_b, busy, y} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b1111}) begin
            errors++;
            $display("FAIL reset: got g_=%b gnt=%b%b busy=%b y=%b want g_=1 gnt=00 busy=0 y=1111",
                     g_, gnt_a, gnt_b, busy, y);
        end
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic test_single();
        req_a = 1'b1;
        step();
        checks++;
        if ({gnt_a, s, g_, y} !== {1'b1, 1'b0, 1'b0, 4'b1010}) begin
            errors++;
            $display("FAIL single_grant: got gnt_a=%b s=%b g_=%b y=%b want 1 0 0 1010", gnt_a, s, g_, y);
        end
        req_a = 1'b0;
        step();
        checks++;
        if ({busy, g_, y} !== {1'b0, 1'b1, 4'b1111}) begin
            errors++;
            $display("FAIL single_release: got busy=%b g_=%b y=%b want 0 1 1111", busy, g_, y);
        end
    endtask

    task automatic test_tie();
        do_reset();
        req_a = 1'b1; req_b = 1'b1;
        step();
        checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errors++;
            $display("FAIL tie_first: got gnt=%b%b want 10", gnt_a, gnt_b);
        end
        req_a = 1'b0;
        step();
        checks++;
        if ({gnt_a, gnt_b, s, g_, y} !== {4'b0011, 4'b1111}) begin
            errors++;
            $display("FAIL tie_dead: got gnt=%b%b s=%b g_=%b y=%b want 00 1 1 1111", gnt_a, gnt_b, s, g_, y);
        end
        step();
        checks++;
        if ({gnt_b, g_, y} !== {1'b1, 1'b0, 4'b1100}) begin
            errors++;
            $display("FAIL tie_handover: got gnt_b=%b g_=%b y=%b want 1 0 1100", gnt_b, g_, y);
        end
        req_b = 1'b0;
        step();
        req_a = 1'b1; req_b = 1'b1;
        step();
        checks++;
        if ({gnt_a, gnt_b} !== 2'b10 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL tie_repeat: got %b want %b (gnt_a first)", dut_vec(), exp_vec());
        end
        req_a = 1'b0; req_b = 1'b0;
        step();
    endtask

    task automatic test_preempt();
        int owned;
        do_reset();
        req_a = 1'b1;
        step();
        req_b = 1'b1;
        owned = 1;
        while (gnt_a && owned < 40) begin
            step();
            if (gnt_a) owned++;
        end
        checks++;
        if (owned !== MAXHOLD) begin
            errors++;
            $display("FAIL preempt_hold: got %0d owned cycles want %0d", owned, MAXHOLD);
        end
        checks++;
        if ({gnt_a, gnt_b, s, g_} !== 4'b0011) begin
            errors++;
            $display("FAIL preempt_dead: got gnt=%b%b s=%b g_=%b want 00 1 1", gnt_a, gnt_b, s, g_);
        end
        step();
        checks++;
        if ({gnt_b, y} !== {1'b1, 4'b1100}) begin
            errors++;
            $display("FAIL preempt_b: got gnt_b=%b y=%b want 1 1100", gnt_b, y);
        end
        req_a = 1'b0; req_b = 1'b0;
        step();
        req_a = 1'b1; req_b = 1'b1;
        step();
        checks++;
        if (gnt_a !== 1'b1 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL preempt_next_tie: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_lock();
        int bad;
        do_reset();
        req_a = 1'b1;
        step();
        req_b = 1'b1; lock = 1'b1;
        bad = 0;
        for (int i = 0; i < 22; i++) begin
            step();
            if (gnt_a !== 1'b1 || g_ !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL lock_hold: got %0d cycles without A ownership want 0", bad);
        end
        lock = 1'b0;
        step();
        checks++;
        if ({gnt_a, g_, s} !== 3'b011) begin
            errors++;
            $display("FAIL lock_release: got gnt_a=%b g_=%b s=%b want 0 1 1", gnt_a, g_, s);
        end
        step();
        checks++;
        if (gnt_b !== 1'b1) begin
            errors++;
            $display("FAIL lock_to_b: got gnt_b=%b want 1", gnt_b);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_b = 1'b1;
        step(); step();
        rst = 1'b1;
        step();
        checks++;
        if ({g_, gnt_b, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid: got g_=%b gnt_b=%b busy=%b want 1 0 0", g_, gnt_b, busy);
        end
        rst = 1'b0; req_a = 1'b1; req_b = 1'b1;
        step();
        checks++;
        if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_tie: got gnt=%b%b want 10", gnt_a, gnt_b);
        end
    endtask

    task automatic test_random();
        int bad_model, bad_inv;
        do_reset();
        bad_model = 0; bad_inv = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) req_a = ~req_a;
            if ($urandom_range(3) == 0) req_b = ~req_b;
            lock = ($urandom_range(5) == 0);
            rst  = ($urandom_range(79) == 0);
            step();
            if (dut_vec() !== exp_vec()) begin
                bad_model++;
                if (bad_model <= 5)
                    $display("FAIL random_model cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            if ((gnt_a && gnt_b) || (g_ !== ~(gnt_a | gnt_b))) bad_inv++;
        end
        checks++;
        if (bad_model != 0) begin
            errors++;
            $display("FAIL random_model: got %0d mismatching cycles want 0", bad_model);
        end
        checks++;
        if (bad_inv != 0) begin
            errors++;
            $display("FAIL random_invariant: got %0d violating cycles want 0", bad_inv);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; lock = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_tie();
        test_preempt();
        test_lock();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
